// File: rtl/risc_v_mike_pkg.sv
// ----------------------------------------------------------------------------
// risc_v_mike_pkg
//
// Purpose : Shared constants and types for the RISC-V "mike" GPIO input
//           conditioner (synchronizer + per-bit debouncer + optional sticky
//           edge flags).
//
// Contents:
//   GPIO_BYTE            - width of the GPIO port handled by the conditioner
//   SYNC_STAGES_DEF      - default synchronizer depth (flops per bit, >= 2)
//   DEBOUNCE_CYCLES_DEF  - default number of consecutive stable synchronized
//                          cycles needed before a new level is accepted (>= 2)
//   t_gpio_vec           - packed vector type, one bit per GPIO pin
//   t_edge_e             - classification of an accepted level change
//   edge_of()            - helper mapping (accept, old level) to t_edge_e
//
// Optional feature macro used by the users of this package:
//   GPIO_EDGE_CAPTURE_EN - enables the sticky rise/fall flag ports and logic.
// ----------------------------------------------------------------------------
package risc_v_mike_pkg;

  localparam int GPIO_BYTE           = 8;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef logic [GPIO_BYTE-1:0] t_gpio_vec;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } t_edge_e;

  // An accepted change always flips the stable level, so the old level alone
  // tells which direction the change went.
  function automatic t_edge_e edge_of(input logic accept, input logic old_level);
    t_edge_e result;
    result = EDGE_NONE;
    if (accept) begin
      result = old_level ? EDGE_FALL : EDGE_RISE;
    end
    return result;
  endfunction

endpackage : risc_v_mike_pkg

// File: rtl/risc_v_mike_debounce_bit.sv
// ----------------------------------------------------------------------------
// risc_v_mike_debounce_bit
//
// Purpose : One GPIO pin worth of input conditioning: a SYNC_STAGES-deep
//           synchronizer followed by a saturating-free debounce counter and
//           the accepted ("stable") level.
//
// Parameters:
//   SYNC_STAGES     - synchronizer depth, >= 2
//   DEBOUNCE_CYCLES - consecutive differing synchronized cycles required to
//                     accept a new level, >= 2
//
// Ports:
//   clk_i     in   clock for all state
//   rst_ni    in   asynchronous active-low reset
//   pad_i     in   raw asynchronous pad level
//   stable_o  out  debounced level (registered)
//   accept_o  out  high in the cycle whose closing edge flips stable_o;
//                  lets the parent capture edges on that same edge
// ----------------------------------------------------------------------------
module risc_v_mike_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  output logic stable_o,
  output logic accept_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  typedef logic [CNT_W-1:0] t_cnt;
  localparam t_cnt CNT_LAST = t_cnt'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  t_cnt                   cnt_q;
  t_cnt                   cnt_d;
  logic                   stable_q;
  logic                   stable_d;
  logic                   accept;

  // Only the last synchronizer stage is ever looked at by the debouncer.
  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  // Counter tracks how long the synchronized level has disagreed with the
  // accepted level. Any agreement restarts it, so glitches shorter than
  // DEBOUNCE_CYCLES never accumulate. The terminal count is consumed by the
  // acceptance itself, so the counter never wraps.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = synced;
      cnt_d    = '0;
      accept   = 1'b1;
    end else begin
      cnt_d = cnt_q + t_cnt'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
  assign accept_o = accept;

endmodule : risc_v_mike_debounce_bit

// File: rtl/risc_v_mike_gpio_conditioner.sv
// ----------------------------------------------------------------------------
// risc_v_mike_gpio_conditioner
//
// Purpose : Conditions the raw GPIO pad inputs before they reach the core:
//           every pin is synchronized and debounced independently by a
//           risc_v_mike_debounce_bit instance. Optionally, sticky rise/fall
//           flags record every accepted level change until cleared.
//
// Configuration macro:
//   GPIO_EDGE_CAPTURE_EN - when defined, the flag ports and flag logic exist.
//                          When undefined they are absent; gpio_port_in
//                          behaves identically in both builds.
//
// Parameters:
//   SYNC_STAGES     - synchronizer flops per bit (>= 2)
//   DEBOUNCE_CYCLES - stable synchronized cycles needed to accept a level (>= 2)
//
// Ports:
//   clk              in   single clock for all state
//   rst              in   asynchronous active-low reset
//   gpio_pad_in      in   raw asynchronous pad levels
//   gpio_port_in     out  debounced levels, feeds the core's gpio_port_in
//   gpio_rise_flags  out  sticky 0->1 flags         (GPIO_EDGE_CAPTURE_EN)
//   gpio_fall_flags  out  sticky 1->0 flags         (GPIO_EDGE_CAPTURE_EN)
//   gpio_flag_clr    in   per-bit clear for both flag vectors, set wins
//                                                   (GPIO_EDGE_CAPTURE_EN)
// ----------------------------------------------------------------------------
module risc_v_mike_gpio_conditioner
  import risc_v_mike_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GPIO_BYTE-1:0] gpio_pad_in,
  output logic [GPIO_BYTE-1:0] gpio_port_in
`ifdef GPIO_EDGE_CAPTURE_EN
  ,
  output logic [GPIO_BYTE-1:0] gpio_rise_flags,
  output logic [GPIO_BYTE-1:0] gpio_fall_flags,
  input  logic [GPIO_BYTE-1:0] gpio_flag_clr
`endif
);

  t_gpio_vec stable;
  t_gpio_vec accept;

  for (genvar gi = 0; gi < GPIO_BYTE; gi++) begin : g_bit
    risc_v_mike_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i   (clk),
      .rst_ni  (rst),
      .pad_i   (gpio_pad_in[gi]),
      .stable_o(stable[gi]),
      .accept_o(accept[gi])
    );
  end

  assign gpio_port_in = stable;

`ifdef GPIO_EDGE_CAPTURE_EN

  t_gpio_vec rise_set;
  t_gpio_vec fall_set;
  t_gpio_vec rise_q;
  t_gpio_vec rise_d;
  t_gpio_vec fall_q;
  t_gpio_vec fall_d;

  // Edge detection uses the debouncer's accept strobe rather than comparing
  // registered levels, so a flag rises on the very edge the level flips.
  for (genvar gi = 0; gi < GPIO_BYTE; gi++) begin : g_edge
    t_edge_e bit_edge;
    assign bit_edge     = edge_of(accept[gi], stable[gi]);
    assign rise_set[gi] = (bit_edge == EDGE_RISE);
    assign fall_set[gi] = (bit_edge == EDGE_FALL);
  end

  // OR-ing the set term after the clear mask makes a coincident set win.
  always_comb begin
    rise_d = (rise_q & ~gpio_flag_clr) | rise_set;
    fall_d = (fall_q & ~gpio_flag_clr) | fall_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign gpio_rise_flags = rise_q;
  assign gpio_fall_flags = fall_q;

`else

  // Without edge capture the accept strobes have no consumer.
  logic unused_accept;
  assign unused_accept = ^accept;

`endif

endmodule : risc_v_mike_gpio_conditioner

// File: tb/tb_risc_v_mike_gpio_conditioner.sv
// ----------------------------------------------------------------------------
// tb_risc_v_mike_gpio_conditioner
//
// Directed bench for the GPIO conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Expected outputs are queued when stimulus is applied
// and popped one per checked edge (or immediately, for async reset checks).
// Flag checks are active only when GPIO_EDGE_CAPTURE_EN is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_risc_v_mike_gpio_conditioner;

  logic       clk;
  logic       rst;
  logic [7:0] pad;
  logic [7:0] port_out;
`ifdef GPIO_EDGE_CAPTURE_EN
  logic [7:0] rise_out;
  logic [7:0] fall_out;
  logic [7:0] clr;
`endif

  typedef struct {
    string      tag;
    logic [7:0] port;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  risc_v_mike_gpio_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gpio_pad_in    (pad),
    .gpio_port_in   (port_out)
`ifdef GPIO_EDGE_CAPTURE_EN
    ,
    .gpio_rise_flags(rise_out),
    .gpio_fall_flags(fall_out),
    .gpio_flag_clr  (clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int n, input logic [7:0] p,
                      input logic [7:0] r, input logic [7:0] f);
    exp_t e;
    e.tag  = tag;
    e.port = p;
    e.rise = r;
    e.fall = f;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_bad++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      assert (port_out === e.port) else begin
        n_bad++;
        $error("FAIL %s port observed=%h expected=%h", e.tag, port_out, e.port);
      end
`ifdef GPIO_EDGE_CAPTURE_EN
      n_cmp++;
      assert (rise_out === e.rise) else begin
        n_bad++;
        $error("FAIL %s rise observed=%h expected=%h", e.tag, rise_out, e.rise);
      end
      n_cmp++;
      assert (fall_out === e.fall) else begin
        n_bad++;
        $error("FAIL %s fall observed=%h expected=%h", e.tag, fall_out, e.fall);
      end
`endif
    end
  endtask

  task automatic check_edges(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_now();
    end
  endtask

  task automatic apply_reset();
    pad = 8'h00;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    pad   = 8'h00;
`ifdef GPIO_EDGE_CAPTURE_EN
    clr   = 8'h00;
`endif

    // Reset state
    repeat (3) tick();
    push("reset", 1, 8'h00, 8'h00, 8'h00);
    check_now();
    rst = 1'b1;

    // Held level: 0 through edge 5, accepted on edge 6 with rise flag
    tick();
    pad = 8'h01;
    push("hold01_wait", 5, 8'h00, 8'h00, 8'h00);
    push("hold01_acc", 1, 8'h01, 8'h01, 8'h00);
    push("hold01_keep", 2, 8'h01, 8'h01, 8'h00);
    check_edges(8);

    // Clear coincident with set: set wins; clear on next edge drops the flag
    apply_reset();
    tick();
    pad = 8'h01;
    push("clr_wait", 5, 8'h00, 8'h00, 8'h00);
    check_edges(5);
`ifdef GPIO_EDGE_CAPTURE_EN
    clr = 8'h01;
`endif
    push("clr_setwins", 1, 8'h01, 8'h01, 8'h00);
    check_edges(1);
    push("clr_applied", 1, 8'h01, 8'h00, 8'h00);
    check_edges(1);
`ifdef GPIO_EDGE_CAPTURE_EN
    clr = 8'h00;
`endif
    push("clr_stays", 2, 8'h01, 8'h00, 8'h00);
    check_edges(2);

    // Glitches: 2-cycle and 3-cycle pulses rejected, counter restarts
    apply_reset();
    tick();
    pad = 8'h01;
    push("pulse2_hi", 2, 8'h00, 8'h00, 8'h00);
    check_edges(2);
    pad = 8'h00;
    push("pulse2_lo", 8, 8'h00, 8'h00, 8'h00);
    check_edges(8);
    pad = 8'h01;
    push("pulse3_hi", 3, 8'h00, 8'h00, 8'h00);
    check_edges(3);
    pad = 8'h00;
    push("pulse3_lo", 8, 8'h00, 8'h00, 8'h00);
    check_edges(8);

    // 4-cycle pulse is exactly long enough: accepted, then released
    pad = 8'h01;
    push("pulse4_hi", 4, 8'h00, 8'h00, 8'h00);
    check_edges(4);
    pad = 8'h00;
    push("pulse4_wait", 1, 8'h00, 8'h00, 8'h00);
    push("pulse4_acc", 4, 8'h01, 8'h01, 8'h00);
    push("pulse4_fall", 1, 8'h00, 8'h01, 8'h01);
    push("pulse4_keep", 2, 8'h00, 8'h01, 8'h01);
    check_edges(8);

    // Multi-bit: A5 then 5A, every bit meets the same latency
    apply_reset();
    tick();
    pad = 8'hA5;
    push("a5_wait", 5, 8'h00, 8'h00, 8'h00);
    push("a5_acc", 3, 8'hA5, 8'hA5, 8'h00);
    check_edges(8);
    pad = 8'h5A;
    push("5a_wait", 5, 8'hA5, 8'hA5, 8'h00);
    push("5a_acc", 3, 8'h5A, 8'hFF, 8'hA5);
    check_edges(8);

    // Reset mid-count: outputs clear at once, full latency after release
    pad = 8'hFF;
    push("rstmid_count", 3, 8'h5A, 8'hFF, 8'hA5);
    check_edges(3);
    rst = 1'b0;
    #2;
    push("rstmid_async", 1, 8'h00, 8'h00, 8'h00);
    check_now();
    push("rstmid_held", 2, 8'h00, 8'h00, 8'h00);
    check_edges(2);
    rst = 1'b1;
    push("rstrel_wait", 5, 8'h00, 8'h00, 8'h00);
    push("rstrel_acc", 2, 8'hFF, 8'hFF, 8'h00);
    check_edges(7);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_risc_v_mike_gpio_conditioner

// File: doc/risc_v_mike_gpio_conditioner.md
RISC_V_MIKE_GPIO_CONDITIONER -- requirements
Module: risc_v_mike_gpio_conditioner

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops per bit (minimum 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the number of consecutive stable synchronized cycles required to accept a new level (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all state.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port gpio_pad_in, input, GPIO_BYTE bits: raw asynchronous pad levels.
REQ-006 The block SHALL have port gpio_port_in, output, GPIO_BYTE bits: debounced levels, driving the core's gpio_port_in.
REQ-007 The block SHALL have port gpio_rise_flags, output, GPIO_BYTE bits: sticky rising-edge flags (present only under the macro in REQ-021).
REQ-008 The block SHALL have port gpio_fall_flags, output, GPIO_BYTE bits: sticky falling-edge flags (present only under the macro in REQ-021).
REQ-009 The block SHALL have port gpio_flag_clr, input, GPIO_BYTE bits: per-bit clear strobe for both flag vectors (present only under the macro in REQ-021).

Function
REQ-010 Each bit SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage SHALL feed the debouncer.
REQ-011 Each bit SHALL have an independent counter of width $clog2(DEBOUNCE_CYCLES) and a stable register.
REQ-012 On any edge where the synchronized bit equals the stable bit, that bit's counter SHALL clear to 0.
REQ-013 On any edge where the bits differ and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 On any edge where the bits differ and the counter equals DEBOUNCE_CYCLES-1, the stable bit SHALL take the synchronized value and the counter SHALL clear; the counter SHALL never wrap.
REQ-015 A pad level held constant SHALL appear on gpio_port_in exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the edge that first samples it.
REQ-016 A pad pulse whose synchronized width is shorter than DEBOUNCE_CYCLES cycles SHALL leave gpio_port_in unchanged and SHALL return the counter to 0.
REQ-017 When a stable bit changes 0->1, the rise flag SHALL set on the same edge; when it changes 1->0, the fall flag SHALL set on the same edge.
REQ-018 Flags SHALL hold until their gpio_flag_clr bit is sampled high; if a set and a clear occur on the same edge, set SHALL win.
REQ-019 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each meet REQ-015.

Reset
REQ-020 While rst is low, all synchronizer flops, counters, stable bits (gpio_port_in) and flags SHALL be 0 immediately (asynchronously); after release, a pad held high SHALL reach gpio_port_in per REQ-015 and SHALL set its rise flag. Reset asserted mid-count SHALL discard the count.

Configuration
REQ-021 Macro GPIO_EDGE_CAPTURE_EN defined: the flag ports and the logic in REQ-017/018 SHALL exist. Macro undefined: those ports and that logic SHALL be absent, and gpio_port_in behaviour SHALL be identical to the defined case.

Structure
REQ-022 GPIO_BYTE and typedef t_gpio_vec (logic [GPIO_BYTE-1:0]) SHALL live in risc_v_mike_pkg; SYNC_STAGES and DEBOUNCE_CYCLES defaults SHALL be package constants.
REQ-023 Per-bit synchronizer, counter and stable logic SHALL be sub-module risc_v_mike_debounce_bit, generated GPIO_BYTE times; flag logic SHALL stay in the parent.

Verification (GPIO_BYTE=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro defined)
REQ-024 Reset, then drive pad 8'h01 at edge 0 and hold -> gpio_port_in=8'h00 through edge 5; 8'h01 after edge 6; rise_flags=8'h01.
REQ-025 Pad bit0 high for 2 cycles, then low -> gpio_port_in stays 8'h00 and no flag sets; counter returns to 0.
REQ-026 Pad 8'hA5 held, then 8'h5A held -> gpio_port_in goes to 8'h5A after 6 edges; rise_flags=8'hFF, fall_flags=8'hA5.
REQ-027 gpio_flag_clr=8'h01 on the same edge bit0 sets its rise flag -> flag remains 1; a clear on the following edge -> flag becomes 0.
REQ-028 rst pulsed low mid-count (3 edges after pad change) -> all outputs 0 at once; after release, full 6-edge latency is observed again.
REQ-029 Rebuild without GPIO_EDGE_CAPTURE_EN and rerun REQ-024..026 -> identical gpio_port_in waveforms; flag ports absent.
